// File: rtl/up_dn_cntr_pkg.sv
// Shared constants and helpers for the up/down counter with load and start/stop.
// Optional terminal-count output is enabled by defining UP_DN_CNTR_TC_EN.
package up_dn_cntr_pkg;

    localparam logic DIR_UP   = 1'b1;
    localparam logic DIR_DOWN = 1'b0;
    localparam logic RUN      = 1'b1;
    localparam logic STOP     = 1'b0;

    // Value the counter holds just before it wraps in the given direction.
    function automatic logic [31:0] term_value(input int unsigned width, input logic dir);
        logic [31:0] all_ones;
        all_ones = 32'hFFFF_FFFF >> (32 - width);
        return (dir == DIR_UP) ? all_ones : 32'h0;
    endfunction

endpackage

// File: rtl/up_dn_cntr_next.sv
// Combinational next-count selector: load, increment, decrement or hold.
// Also produces the terminal-count flag when UP_DN_CNTR_TC_EN is defined.
module up_dn_cntr_next
    import up_dn_cntr_pkg::*;
#(
    parameter int unsigned WIDTH = 4
) (
    input  logic [WIDTH-1:0] cnt,
    input  logic             load_en,
    input  logic [WIDTH-1:0] load_data,
    input  logic             up_dnb,
    input  logic             start_stop_b,
`ifdef UP_DN_CNTR_TC_EN
    output logic             tc,
`endif
    output logic [WIDTH-1:0] cnt_next
);

    localparam logic [WIDTH-1:0] MAX_VAL = WIDTH'(term_value(WIDTH, DIR_UP));
    localparam logic [WIDTH-1:0] MIN_VAL = WIDTH'(term_value(WIDTH, DIR_DOWN));

    always_comb begin
        cnt_next = cnt;
        if (load_en) begin
            cnt_next = load_data;
        end else if (start_stop_b == RUN) begin
            // Plain modular arithmetic gives the silent wrap in both directions.
            if (up_dnb == DIR_UP) begin
                cnt_next = cnt + WIDTH'(1);
            end else begin
                cnt_next = cnt - WIDTH'(1);
            end
        end
    end

`ifdef UP_DN_CNTR_TC_EN
    always_comb begin
        tc = 1'b0;
        if (!load_en && start_stop_b == RUN) begin
            tc = (up_dnb == DIR_UP) ? (cnt == MAX_VAL) : (cnt == MIN_VAL);
        end
    end
`else
    // Terminal values are only consumed by the tc logic.
    logic unused_term;
    assign unused_term = ^{MAX_VAL, MIN_VAL};
`endif

endmodule

// File: rtl/up_dn_cntr_load_start_stop.sv
// WIDTH-bit up/down counter with parallel load and run/hold control.
// Define UP_DN_CNTR_TC_EN to add the terminal-count output tc.
module up_dn_cntr_load_start_stop
    import up_dn_cntr_pkg::*;
#(
    parameter int unsigned WIDTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load_en,
    input  logic [WIDTH-1:0] load_data,
    input  logic             up_dnb,
    input  logic             start_stop_b,
`ifdef UP_DN_CNTR_TC_EN
    output logic             tc,
`endif
    output logic [WIDTH-1:0] cnt
);

    logic [WIDTH-1:0] cnt_next;

    up_dn_cntr_next #(
        .WIDTH(WIDTH)
    ) u_next (
        .cnt         (cnt),
        .load_en     (load_en),
        .load_data   (load_data),
        .up_dnb      (up_dnb),
        .start_stop_b(start_stop_b),
`ifdef UP_DN_CNTR_TC_EN
        .tc          (tc),
`endif
        .cnt_next    (cnt_next)
    );

    always_ff @(posedge clk) begin
        if (!reset) begin
            cnt <= '0;
        end else begin
            cnt <= cnt_next;
        end
    end

endmodule

// File: tb/tb_up_dn_cntr_load_start_stop.sv
// Self-checking bench: directed scenarios plus a random run against an arithmetic model.
// Checks tc as well when UP_DN_CNTR_TC_EN is defined.
module tb_up_dn_cntr_load_start_stop;

    localparam int unsigned W   = 4;
    localparam longint      MOD = longint'(1) << W;

    logic         clk = 1'b0;
    logic         reset;
    logic         load_en;
    logic [W-1:0] load_data;
    logic         up_dnb;
    logic         start_stop_b;
    logic [W-1:0] cnt;
`ifdef UP_DN_CNTR_TC_EN
    logic         tc;
`endif

    int     n_checks = 0;
    int     n_fail   = 0;
    longint model    = 0;

    up_dn_cntr_load_start_stop #(
        .WIDTH(W)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .load_en     (load_en),
        .load_data   (load_data),
        .up_dnb      (up_dnb),
        .start_stop_b(start_stop_b),
`ifdef UP_DN_CNTR_TC_EN
        .tc          (tc),
`endif
        .cnt         (cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input longint obs, input longint exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    // Apply one cycle of inputs; exp >= 0 adds a directed check of the new count.
    task automatic step(input logic r, input logic ld, input logic [W-1:0] d,
                        input logic up, input logic run, input int exp, input string tag);
        reset        = r;
        load_en      = ld;
        load_data    = d;
        up_dnb       = up;
        start_stop_b = run;
        @(negedge clk);
`ifdef UP_DN_CNTR_TC_EN
        check({tag, "_tc"}, longint'(tc),
              longint'(run && !ld && ((up && model == MOD - 1) || (!up && model == 0))));
`endif
        @(posedge clk);
        if (!r)        model = 0;
        else if (ld)   model = longint'(d);
        else if (run)  model = up ? (model + 1) % MOD : (model + MOD - 1) % MOD;
        #1;
        check({tag, "_model"}, longint'(cnt), model);
        if (exp >= 0) check(tag, longint'(cnt), longint'(exp));
    endtask

    initial begin
        reset = 1'b0; load_en = 1'b0; load_data = '0; up_dnb = 1'b1; start_stop_b = 1'b1;
        @(posedge clk); #1;
        model = 0;

        // Reset held while running up, then release.
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 4'h0, 1'b1, 1'b1, 0, "rst_hold");
        step(1'b1, 1'b0, 4'h0, 1'b1, 1'b1, 1, "rst_rel1");
        step(1'b1, 1'b0, 4'h0, 1'b1, 1'b1, 2, "rst_rel2");
        step(1'b1, 1'b0, 4'h0, 1'b1, 1'b1, 3, "rst_rel3");

        // Wrap up and down.
        step(1'b1, 1'b1, 4'hE, 1'b1, 1'b1, 14, "wrap_ld_e");
        step(1'b1, 1'b0, 4'h0, 1'b1, 1'b1, 15, "wrap_up_f");
        step(1'b1, 1'b0, 4'h0, 1'b1, 1'b1, 0,  "wrap_up_0");
        step(1'b1, 1'b0, 4'h0, 1'b1, 1'b1, 1,  "wrap_up_1");
        step(1'b1, 1'b1, 4'h1, 1'b0, 1'b1, 1,  "wrap_ld_1");
        step(1'b1, 1'b0, 4'h0, 1'b0, 1'b1, 0,  "wrap_dn_0");
        step(1'b1, 1'b0, 4'h0, 1'b0, 1'b1, 15, "wrap_dn_f");
        step(1'b1, 1'b0, 4'h0, 1'b0, 1'b1, 14, "wrap_dn_e");

        // Hold and restart.
        step(1'b1, 1'b1, 4'h5, 1'b1, 1'b1, 5, "hold_ld");
        for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 4'h0, 1'b1, 1'b0, 5, "hold");
        step(1'b1, 1'b0, 4'h0, 1'b1, 1'b1, 6, "hold_restart");

        // Load beats stop and counting.
        step(1'b1, 1'b1, 4'h9, 1'b1, 1'b0, 9,  "ldp_pre");
        step(1'b1, 1'b1, 4'h3, 1'b1, 1'b0, 3,  "ldp_stop");
        step(1'b1, 1'b0, 4'h0, 1'b1, 1'b0, 3,  "ldp_held");
        step(1'b1, 1'b1, 4'hA, 1'b0, 1'b1, 10, "ldp_run_dn");
        step(1'b1, 1'b0, 4'h0, 1'b0, 1'b1, 9,  "ldp_after");

        // Direction toggle with no dead cycle.
        step(1'b1, 1'b1, 4'h7, 1'b1, 1'b1, 7, "dir_ld");
        step(1'b1, 1'b0, 4'h0, 1'b1, 1'b1, 8, "dir_up");
        step(1'b1, 1'b0, 4'h0, 1'b0, 1'b1, 7, "dir_dn1");
        step(1'b1, 1'b0, 4'h0, 1'b0, 1'b1, 6, "dir_dn2");

        // Random run.
        for (int i = 0; i < 700; i++) begin
            step(($urandom_range(99) >= 2), ($urandom_range(99) < 20), W'($urandom),
                 1'($urandom), ($urandom_range(99) < 75), -1, "rand");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/up_dn_cntr_load_start_stop.md
# up_dn_cntr_load_start_stop

Synchronous WIDTH-bit up/down counter with parallel load and a run/hold (start/stop) control. It is a general-purpose counting primitive for timers, address generators and sequence counters: load presets the count, `up_dnb` selects the direction, and `start_stop_b` gates counting.

## Interface
- `WIDTH`, default 4: counter and load-data width; legal range 2..32.
- `clk`  in  1  rising-edge clock; all state changes on this edge.
- `reset`  in  1  one clock; reset is synchronous and active-low (0 = reset).
- `load_en`  in  1  1 = load `load_data` into the counter on this edge.
- `load_data`  in  WIDTH  preset value.
- `up_dnb`  in  1  direction: 1 = count up, 0 = count down.
- `start_stop_b`  in  1  1 = run (count), 0 = stop (hold).
- `cnt`  out  WIDTH  current count, registered.
- `tc`  out  1  terminal count; present only with `UP_DN_CNTR_TC_EN`.

## Operation
- Priority per rising `clk`, highest first:
  - `reset`=0: `cnt` <= 0.
  - `load_en`=1: `cnt` <= `load_data`. Load works regardless of `start_stop_b` and `up_dnb`.
  - `start_stop_b`=1 and `up_dnb`=1: `cnt` <= `cnt`+1, modulo 2^WIDTH.
  - `start_stop_b`=1 and `up_dnb`=0: `cnt` <= `cnt`-1, modulo 2^WIDTH.
  - `start_stop_b`=0: `cnt` holds.
- Wrap-around is silent, with no saturation:
  - up from 2^WIDTH-1 gives 0;
  - down from 0 gives 2^WIDTH-1.
- `load_en` is level-sensitive. Held high for N cycles, it reloads on each of those N edges, so the count stays at `load_data` (tracking any changes to it).
- Direction may change on any cycle. The new direction applies at the next edge, with no dead cycle.
- Inputs are synchronous to `clk`; the block contains no synchronizers.

## Timing
- Reset value: `cnt`=0; `tc` follows its combinational definition from `cnt`.
- Latency is 1 cycle. Inputs sampled at edge k appear on `cnt` after edge k; `cnt` is a direct flop output.
- Reset takes effect only at a clock edge. Deasserting mid-operation resumes per inputs on the first edge with `reset`=1, starting from 0.
- Stop then start: the count resumes from the held value on the first edge with `start_stop_b`=1.
- Load and stop asserted together: the value is loaded and then held.

## Configuration
- `UP_DN_CNTR_TC_EN` defined:
  - adds output `tc`, which is combinational from registered state;
  - `tc`=1 when `start_stop_b`=1 and `load_en`=0 and either `up_dnb`=1 with `cnt`=2^WIDTH-1, or `up_dnb`=0 with `cnt`=0;
  - `tc` therefore flags that the next edge wraps.
- Undefined: no `tc` port. Counting behaviour is identical in both cases.

## Structure
- Shared package `up_dn_cntr_pkg`:
  - direction constants `DIR_UP`=1'b1, `DIR_DOWN`=1'b0;
  - run constants `RUN`=1'b1, `STOP`=1'b0;
  - a helper function computing all-ones/zero terminal values for a given width.
- One sub-module is natural: `up_dn_cntr_next`, a purely combinational next-state selector (load/inc/dec/hold mux, plus `tc` when enabled).
- The top level keeps only the register and the reset.

## Test plan
- Reset: `reset`=0 for 3 cycles with `start_stop_b`=1, `up_dnb`=1 -> `cnt`=0 throughout; after release, 1, 2, 3 on successive edges.
- Wrap: load 4'hE, then run up -> `cnt` goes E, F, 0, 1. Run down from 4'h1 -> 1, 0, F, E. With the macro, `tc`=1 exactly while `cnt`=F going up and while `cnt`=0 going down.
- Hold: counting up at 5, drop `start_stop_b` for 4 cycles -> `cnt` stays 5; on restart -> 6.
- Load priority: `cnt`=9, `load_en`=1 pulse with `load_data`=3 while `start_stop_b`=0 -> `cnt`=3 next cycle and held; `load_en`=1 while running down -> loaded value, no decrement that edge.
- Direction toggle: running at 7, flip `up_dnb` 1->0 -> 8 then 7, 6.
- Random long run (about 700 cycles) with independent random `load_en` pulses, `load_data` changes, `up_dnb` and `start_stop_b` toggles, compared against a reference model each cycle.
